// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one imem read per instruction, handed to decode.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned next-PCs in S_FAULT.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             imem_resp_ready,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             npc_valid,
  input  logic [31:0]      npc,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign_fault
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic req_q, req_d;
  logic rsp_q, rsp_d;
  logic vld_q, vld_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (npc_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = npc;
            state_d = S_REQ;
          end
`else
          pc_d    = {npc[31:2], 2'b00};
          state_d = S_REQ;
`endif
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  // Handshake flags are registered from the next state.
  always_comb begin
    req_d  = 1'b0;
    rsp_d  = 1'b0;
    vld_d  = 1'b0;
    busy_d = 1'b1;
    unique case (1'b1)
      (state_d == S_REQ):  req_d  = 1'b1;
      (state_d == S_WAIT): rsp_d  = 1'b1;
      (state_d == S_HOLD): vld_d  = 1'b1;
      (state_d == S_EXEC): busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      inst_q  <= 32'h0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      req_q   <= 1'b1;
      rsp_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  // Handshakes are forced quiet for as long as rst is held.
  assign imem_req_valid  = req_q & ~rst;
  assign imem_resp_ready = rsp_q & ~rst;
  assign inst_valid      = vld_q & ~rst;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign busy      = busy_q;
  assign fetch_cnt = cnt_q;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_fault = fault_q;
`else
  logic unused_npc_lsb;
  assign unused_npc_lsb = ^{npc[1:0], fault_q};
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch with a transaction-level PC/count model.
// Covers misaligned-PC handling for both IFU_MISALIGN_CHECK_EN builds.
module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        busy;
  logic [31:0] fetch_cnt;
  logic        misalign_fault;

  ifu_fetch #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_ready(imem_resp_ready),
    .inst(inst), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .npc_valid(npc_valid), .npc(npc),
    .busy(busy), .fetch_cnt(fetch_cnt),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  int          acc_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    npc_valid       = 1'b0;
  endtask

  // Inputs that the current state must ignore.
  task automatic junk(input bit rsp);
    npc_valid  = 1'($urandom);
    npc        = $urandom;
    inst_ready = 1'($urandom);
    if (rsp) begin
      imem_resp_valid = 1'($urandom);
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic quiet_chk(input string tag);
    chk({tag, "_reqv"}, 32'(imem_req_valid), 0);
    chk({tag, "_rspr"}, 32'(imem_resp_ready), 0);
    chk({tag, "_ival"}, 32'(inst_valid), 0);
  endtask

  task automatic fetch_one(input int rs, input int rd, input int hd,
                           input int nd, input logic [31:0] word,
                           input logic [31:0] nv, input bit pulse,
                           output bit faulted);
    faulted = 1'b0;
    chk("req_valid", 32'(imem_req_valid), 1);
    chk("req_addr", imem_addr, exp_pc);
    chk("req_rspr", 32'(imem_resp_ready), 0);
    chk("req_ival", 32'(inst_valid), 0);
    chk("req_busy", 32'(busy), 1);
    chk("req_fault", 32'(misalign_fault), 0);
    for (int i = 0; i < rs; i++) begin
      junk(1'b1);
      imem_req_ready = 1'b0;
      step();
      chk("stall_reqv", 32'(imem_req_valid), 1);
      chk("stall_addr", imem_addr, exp_pc);
      chk("stall_rspr", 32'(imem_resp_ready), 0);
    end
    junk(1'b1);
    imem_req_ready = 1'b1;
    step();
    acc_cyc = cyc;
    clear_in();
    for (int i = 0; i < rd; i++) begin
      junk(1'b0);
      imem_resp_valid = 1'b0;
      chk("wait_rspr", 32'(imem_resp_ready), 1);
      chk("wait_reqv", 32'(imem_req_valid), 0);
      chk("wait_ival", 32'(inst_valid), 0);
      step();
    end
    chk("wait_rspr", 32'(imem_resp_ready), 1);
    junk(1'b0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    step();
    clear_in();
    chk("hold_ival", 32'(inst_valid), 1);
    chk("hold_inst", inst, word);
    chk("hold_pc", pc, exp_pc);
    chk("hold_cnt", fetch_cnt, exp_cnt);
    chk("hold_rspr", 32'(imem_resp_ready), 0);
    chk("hold_reqv", 32'(imem_req_valid), 0);
    for (int i = 0; i < hd; i++) begin
      imem_resp_valid = 1'($urandom);
      imem_resp_data  = $urandom;
      if (pulse && i == 0) begin
        npc_valid = 1'b1;
        npc       = ~exp_pc & 32'hFFFF_FFFC;
      end
      step();
      npc_valid = 1'b0;
      chk("hstall_ival", 32'(inst_valid), 1);
      chk("hstall_inst", inst, word);
      chk("hstall_pc", pc, exp_pc);
    end
    clear_in();
    inst_ready = 1'b1;
    step();
    clear_in();
    exp_cnt = exp_cnt + 1;
    chk("exec_ival", 32'(inst_valid), 0);
    chk("exec_busy", 32'(busy), 0);
    chk("exec_reqv", 32'(imem_req_valid), 0);
    chk("exec_cnt", fetch_cnt, exp_cnt);
    chk("exec_inst", inst, word);
    chk("exec_pc", pc, exp_pc);
    for (int i = 0; i < nd; i++) begin
      junk(1'b1);
      npc_valid = 1'b0;
      step();
      chk("exwait_busy", 32'(busy), 0);
      chk("exwait_pc", pc, exp_pc);
    end
    clear_in();
    npc_valid = 1'b1;
    npc       = nv;
    step();
    clear_in();
`ifdef IFU_MISALIGN_CHECK_EN
    if (nv[1:0] != 2'b00) faulted = 1'b1;
    else exp_pc = nv;
`else
    exp_pc = {nv[31:2], 2'b00};
`endif
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    quiet_chk("rst");
    imem_resp_valid = 1'b1;
    step();
    quiet_chk("rst2");
    clear_in();
    rst = 1'b0;
    #1;
    exp_pc  = RPC;
    exp_cnt = 0;
    chk("post_rst_reqv", 32'(imem_req_valid), 1);
    chk("post_rst_addr", imem_addr, RPC);
    chk("post_rst_cnt", fetch_cnt, 0);
    chk("post_rst_inst", inst, 0);
    chk("post_rst_fault", 32'(misalign_fault), 0);
  endtask

  initial begin
    int a1;
    bit flt;
    logic [31:0] nv;
    exp_pc  = RPC;
    exp_cnt = 0;
    step();
    quiet_chk("init");
    step();
    rst = 1'b0;
    #1;
    chk("first_reqv", 32'(imem_req_valid), 1);
    chk("first_addr", imem_addr, RPC);
    chk("first_ival", 32'(inst_valid), 0);
    chk("first_cnt", fetch_cnt, 0);

    fetch_one(0, 0, 0, 0, 32'h0010_0093, 32'h8000_0004, 1'b0, flt);
    a1 = acc_cyc;
    fetch_one(0, 0, 0, 0, $urandom, 32'h8000_0008, 1'b0, flt);
    chk("lat4", 32'(acc_cyc - a1), 4);
    fetch_one(2, 3, 0, 0, $urandom, 32'h8000_0100, 1'b0, flt);
    fetch_one(0, 0, 5, 1, $urandom, 32'h8000_0100, 1'b1, flt);

    // Abort in S_WAIT, then a stray response right after release.
    chk("rw_addr", imem_addr, exp_pc);
    imem_req_ready = 1'b1;
    step();
    clear_in();
    chk("rw_rspr", 32'(imem_resp_ready), 1);
    do_reset();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    clear_in();
    chk("late_reqv", 32'(imem_req_valid), 1);
    chk("late_rspr", 32'(imem_resp_ready), 0);
    chk("late_inst", inst, 0);

    fetch_one(0, 0, 0, 0, $urandom, 32'h8000_0006, 1'b0, flt);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_flag", 32'(flt), 1);
    for (int i = 0; i < 4; i++) begin
      junk(1'b1);
      imem_req_ready = 1'b1;
      chk("mis_fault", 32'(misalign_fault), 1);
      chk("mis_busy", 32'(busy), 1);
      chk("mis_pc", pc, RPC);
      quiet_chk("mis");
      step();
    end
    do_reset();
`else
    chk("mis_addr", imem_addr, 32'h8000_0004);
`endif

    fetch_one(1, 1, 1, 1, $urandom, 32'hFFFF_FFFC, 1'b0, flt);
    fetch_one(0, 0, 0, 0, $urandom, exp_pc + 32'd4, 1'b0, flt);
    chk("wrap_addr", imem_addr, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: nv = exp_pc;
        1: nv = exp_pc + 32'd4;
        2: nv = $urandom & 32'hFFFF_FFFC;
        default: nv = $urandom;
      endcase
`ifdef IFU_MISALIGN_CHECK_EN
      nv[1:0] = 2'b00;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, nv, 1'($urandom), flt);
    end
    chk("final_cnt", fetch_cnt, exp_cnt);
    chk("final_addr", imem_addr, exp_pc);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
